// File: rtl/aprx_fp_widen_if.sv
// ============================================================================
// aprx_fp_widen_if : narrow-in / binary32-out streaming bundle  (rev 1.0)
// ============================================================================
`default_nettype none

interface aprx_fp_widen_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic [2:0]  out_flags;

   // Producer/consumer side: drives words in, accepts beats out.
   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_flags
   );

   // Converter side.
   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_last, out_flags
   );
endinterface

`default_nettype wire

// File: rtl/aprx_fp_widen.sv
// ============================================================================
// aprx_fp_widen : binary16alt / 2x binary8 to binary32 streaming up-converter
// rev 1.0
// ============================================================================
`default_nettype none

module aprx_fp_widen #(
   parameter bit FLUSH_DENORM = 1'b1
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   aprx_fp_widen_if.slave bus
);

   localparam logic [2:0] FLAG_NONE    = 3'b000;
   localparam logic [2:0] FLAG_NAN     = 3'b100;
   localparam logic [2:0] FLAG_INF     = 3'b010;
   localparam logic [2:0] FLAG_FLUSHED = 3'b001;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [2:0]  flags;
      logic [31:0] data;
   } beat_t;

   function automatic beat_t conv16(input logic [15:0] x);
      beat_t      r;
      logic       s;
      logic [7:0] e;
      logic [6:0] m;
      s       = x[15];
      e       = x[14:7];
      m       = x[6:0];
      r.flags = FLAG_NONE;
      // Same exponent bias, so every non-flushed case is a plain zero-extension.
      r.data  = {s, e, m, 16'h0000};
      if (e == 8'hFF) begin
         r.flags = (m == 7'd0) ? FLAG_INF : FLAG_NAN;
      end else if ((e == 8'h00) && (m != 7'd0) && FLUSH_DENORM) begin
         r.data  = {s, 31'h0};
         r.flags = FLAG_FLUSHED;
      end
      return r;
   endfunction

   function automatic beat_t conv8(input logic [7:0] x);
      beat_t      r;
      logic       s;
      logic [4:0] e;
      logic [1:0] m;
      s       = x[7];
      e       = x[6:2];
      m       = x[1:0];
      r.flags = FLAG_NONE;
      r.data  = {s, 31'h0};
      if (e == 5'h1F) begin
         r.data  = {s, 8'hFF, m, 21'h0};
         r.flags = (m == 2'd0) ? FLAG_INF : FLAG_NAN;
      end else if (e != 5'h00) begin
         r.data = {s, {3'b000, e} + 8'd112, m, 21'h0};
      end else if (m != 2'd0) begin
         if (FLUSH_DENORM) begin
            r.flags = FLAG_FLUSHED;
         end else begin
            // Subnormal value m * 2^-16, renormalised into binary32.
            case (m)
               2'b01:   r.data = {s, 8'd111, 23'h0};
               2'b10:   r.data = {s, 8'd112, 23'h0};
               default: r.data = {s, 8'd112, 1'b1, 22'h0};
            endcase
         end
      end
      return r;
   endfunction

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  pend;
   logic [7:0]  pend_nxt;
   logic        valid_q;
   logic        valid_nxt;
   logic [31:0] data_q;
   logic [31:0] data_nxt;
   logic        last_q;
   logic        last_nxt;
   logic [2:0]  flags_q;
   logic [2:0]  flags_nxt;

   logic        in_ready;
   logic        accept;
   logic        consume;
   beat_t       cv16;
   beat_t       cv_lo;
   beat_t       cv_pend;

   assign in_ready = rst_n && (state == IDLE) && (!valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = valid_q && bus.out_ready;

   assign cv16    = conv16(bus.in_data);
   assign cv_lo   = conv8(bus.in_data[7:0]);
   assign cv_pend = conv8(pend);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      valid_nxt = valid_q;
      data_nxt  = data_q;
      last_nxt  = last_q;
      flags_nxt = flags_q;
      case (state)
         IDLE: begin
            if (accept) begin
               valid_nxt = 1'b1;
               if (!bus.in_mode) begin
                  data_nxt  = cv16.data;
                  flags_nxt = cv16.flags;
                  last_nxt  = 1'b1;
               end else begin
                  data_nxt  = cv_lo.data;
                  flags_nxt = cv_lo.flags;
                  last_nxt  = 1'b0;
                  pend_nxt  = bus.in_data[15:8];
                  state_nxt = PEND;
               end
            end else if (consume) begin
               valid_nxt = 1'b0;
            end
         end
         PEND: begin
            // Lane0 beat is always valid here; lane1 replaces it once taken.
            if (consume) begin
               valid_nxt = 1'b1;
               data_nxt  = cv_pend.data;
               flags_nxt = cv_pend.flags;
               last_nxt  = 1'b1;
               pend_nxt  = 8'h00;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pend    <= 8'h00;
         valid_q <= 1'b0;
         data_q  <= 32'h0;
         last_q  <= 1'b0;
         flags_q <= 3'b000;
      end else begin
         state   <= state_nxt;
         pend    <= pend_nxt;
         valid_q <= valid_nxt;
         data_q  <= data_nxt;
         last_q  <= last_nxt;
         flags_q <= flags_nxt;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_last  = last_q;
   assign bus.out_flags = flags_q;

endmodule

`default_nettype wire
